move_input_ctrl: RTL

MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

---
 rtl/move_pkg.sv | 39 +++
 rtl/move_input_ctrl_if.sv | 27 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/move_input_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// move_pkg: shared definitions for the movement input controller.
// Holds the one-hot direction encodings, the FSM state type, the default
// parameter values and the fixed-priority direction selector.
package move_pkg;

    // One-hot move encodings as seen by the player move stage.
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_NONE  = 4'b0000;

    localparam int unsigned DEF_DEBOUNCE_CYCLES    = 250000;
    localparam int unsigned DEF_TICK_CYCLES        = 1000000;
    localparam int unsigned DEF_REPEAT_DELAY_TICKS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFirst,
        StDelay,
        StRepeat,
        StLockout
    } move_state_t;

    // Fixed priority up > down > left > right; result is always one-hot or zero.
    function automatic logic [3:0] prio_sel(input logic [3:0] lvl);
        if (lvl[3]) begin
            return DIR_UP;
        end else if (lvl[2]) begin
            return DIR_DOWN;
        end else if (lvl[1]) begin
            return DIR_LEFT;
        end else if (lvl[0]) begin
            return DIR_RIGHT;
        end
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// move_input_ctrl_if: button/move bundle between the board-side driver and the
// movement controller.
//   btn_raw   [3:0] asynchronous buttons (bit3 up, bit2 down, bit1 left, bit0 right)
//   freeze          game-over/win hold, suppresses all movement
//   move_dir  [3:0] one-hot single-cycle move command
//   btn_level [3:0] debounced button levels
// Modports: master drives buttons/freeze, slave is the controller.
interface move_input_ctrl_if;
    logic [3:0] btn_raw;
    logic       freeze;
    logic [3:0] move_dir;
    logic [3:0] btn_level;

    modport master (
        output btn_raw,
        output freeze,
        input  move_dir,
        input  btn_level
    );

    modport slave (
        input  btn_raw,
        input  freeze,
        output move_dir,
        output btn_level
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one button bit through a 2-flop synchroniser and a
// consecutive-disagreement debouncer.
//   clk   system clock
//   rst   synchronous active-high reset
//   raw   asynchronous button input
//   level debounced level; flips after DEBOUNCE_CYCLES consecutive
//         cycles of the synchronised value disagreeing with it
module btn_debounce
    import move_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This is the DEBOUNCE_CYCLES-th disagreeing cycle.
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: turns four raw buttons into one-hot single-cycle move
// commands with first-move, hold delay and tick-paced auto-repeat.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  move_input_ctrl_if.slave: btn_raw/freeze in, move_dir/btn_level out
module move_input_ctrl
    import move_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_CYCLES        = DEF_TICK_CYCLES,
    parameter int unsigned REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS
) (
    input  logic               clk,
    input  logic               rst,
    move_input_ctrl_if.slave   bus
);

    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DW = (REPEAT_DELAY_TICKS > 1) ? $clog2(REPEAT_DELAY_TICKS) : 1;

    logic [3:0]    level;
    logic [3:0]    sel_dir;
    logic [PW-1:0] presc;
    logic          tick;
    logic [DW-1:0] delay_cnt;
    logic [3:0]    cur_dir;
    logic [3:0]    move_q;
    move_state_t   state;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.btn_raw[i]),
            .level (level[i])
        );
    end

    assign sel_dir       = prio_sel(level);
    assign bus.btn_level = level;
    assign bus.move_dir  = move_q;

    // Free-running movement prescaler.
    assign tick = (presc == PW'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // move_q is registered: the edge that enters StFirst (or acts on a repeat
    // tick) loads the move, so it is visible for exactly one cycle after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cur_dir   <= DIR_NONE;
            delay_cnt <= '0;
            move_q    <= DIR_NONE;
        end else begin
            move_q <= DIR_NONE;
            if (bus.freeze) begin
                state <= StLockout;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (sel_dir != DIR_NONE) begin
                            cur_dir <= sel_dir;
                            move_q  <= sel_dir;
                            state   <= StFirst;
                        end
                    end
                    StFirst: begin
                        delay_cnt <= '0;
                        state     <= StDelay;
                    end
                    StDelay, StRepeat: begin
                        if (sel_dir == DIR_NONE) begin
                            state <= StIdle;
                        end else if (sel_dir != cur_dir) begin
                            // A coinciding tick is absorbed: one move, new direction.
                            cur_dir <= sel_dir;
                            move_q  <= sel_dir;
                            state   <= StFirst;
                        end else if (tick) begin
                            if (state == StRepeat) begin
                                move_q <= cur_dir;
                            end else if (delay_cnt == DW'(REPEAT_DELAY_TICKS - 1)) begin
                                state <= StRepeat;
                            end else begin
                                delay_cnt <= delay_cnt + 1'b1;
                            end
                        end
                    end
                    StLockout: begin
                        // Wait for every button to be released so a held button
                        // cannot fire when freeze drops.
                        if (level == 4'b0000) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
